// File: rtl/sccb_init_sequencer.sv
// Table-driven OV7670 register initialiser driving CoreSCCB's request bus.
// Optional build macro SCCB_READBACK_VERIFY_EN adds read-back verification of non-COM7 writes.
module sccb_init_sequencer #(
   parameter logic [6:0] DEV_ADDR   = 7'h21,
   parameter int         DELAY_UNIT = 100,
   parameter int         TIMEOUT    = 4095
) (
   input  logic       PCLK,
   input  logic       PRESETN,
   input  logic       step,
   input  logic       go,
   output logic       start,
   output logic       rw,
   output logic [6:0] ip_addr,
   output logic [7:0] sub_addr,
   output logic [7:0] data_in,
   input  logic       done,
   input  logic [7:0] data_out,
   output logic       busy,
   output logic       cfg_done,
   output logic       error,
   output logic [4:0] err_index
);

   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_FETCH   = 4'd1;
   localparam logic [3:0] S_WR_REQ  = 4'd2;
   localparam logic [3:0] S_WR_WAIT = 4'd3;
   localparam logic [3:0] S_REL     = 4'd4;
   localparam logic [3:0] S_DELAY   = 4'd5;
   localparam logic [3:0] S_DONE    = 4'd6;
   localparam logic [3:0] S_ERR     = 4'd7;
`ifdef SCCB_READBACK_VERIFY_EN
   localparam logic [3:0] S_RD_REQ  = 4'd8;
   localparam logic [3:0] S_RD_WAIT = 4'd9;
   localparam logic [3:0] S_RD_REL  = 4'd10;
   localparam logic [7:0] ADDR_COM7 = 8'h12;
`endif

   localparam logic [7:0]  ADDR_END   = 8'hFF;
   localparam logic [7:0]  ADDR_DELAY = 8'hF0;
   localparam logic [15:0] TMO_MAX    = 16'(TIMEOUT);

   logic [3:0]  state;
   logic [4:0]  index;
   logic [15:0] dly;
   logic [15:0] tmo;
   logic [7:0]  entry_addr;
   logic [7:0]  entry_data;
   logic [15:0] dly_load;
   logic        waiting;
   logic        edge_seen;

`ifdef SCCB_READBACK_VERIFY_EN
   logic rw_q;
   assign rw = rw_q;
`else
   logic unused_data_out;
   assign rw              = 1'b0;
   assign unused_data_out = ^data_out;
`endif

   // Init table: {register address, data}; F0 marks a delay, FF ends the walk.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      entry_addr = 8'hFF;
      entry_data = 8'hFF;
      case (index)
         5'd0:    begin entry_addr = 8'h12; entry_data = 8'h80; end
         5'd1:    begin entry_addr = 8'hF0; entry_data = 8'h0A; end
         5'd2:    begin entry_addr = 8'h12; entry_data = 8'h14; end
         5'd3:    begin entry_addr = 8'h40; entry_data = 8'hD0; end
         5'd4:    begin entry_addr = 8'h8C; entry_data = 8'h00; end
         5'd5:    begin entry_addr = 8'h11; entry_data = 8'h01; end
         default: ;
      endcase
   end

   assign dly_load = 16'(32'(entry_data) * 32'(DELAY_UNIT));

   // States that wait on a done edge share one timeout counter.
   always_comb begin
      waiting   = 1'b0;
      edge_seen = 1'b0;
      case (state)
         S_WR_WAIT: begin waiting = 1'b1; edge_seen = done;  end
         S_REL:     begin waiting = 1'b1; edge_seen = !done; end
`ifdef SCCB_READBACK_VERIFY_EN
         S_RD_WAIT: begin waiting = 1'b1; edge_seen = done;  end
         S_RD_REL:  begin waiting = 1'b1; edge_seen = !done; end
`endif
         default: ;
      endcase
   end

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         state     <= S_IDLE;
         index     <= '0;
         dly       <= '0;
         tmo       <= '0;
         start     <= 1'b0;
         ip_addr   <= '0;
         sub_addr  <= '0;
         data_in   <= '0;
         busy      <= 1'b0;
         cfg_done  <= 1'b0;
         error     <= 1'b0;
         err_index <= '0;
`ifdef SCCB_READBACK_VERIFY_EN
         rw_q      <= 1'b0;
`endif
      end else if (step) begin
         if (waiting && !edge_seen) begin
            if (tmo == TMO_MAX) begin
               state     <= S_ERR;
               error     <= 1'b1;
               err_index <= index;
               start     <= 1'b0;
               busy      <= 1'b0;
            end else begin
               tmo <= tmo + 16'd1;
            end
         end else begin
            case (state)
               S_IDLE: begin
                  if (go) begin
                     index <= '0;
                     busy  <= 1'b1;
                     state <= S_FETCH;
                  end
               end
               S_FETCH: begin
                  if (entry_addr == ADDR_END) begin
                     cfg_done <= 1'b1;
                     busy     <= 1'b0;
                     state    <= S_DONE;
                  end else if (entry_addr == ADDR_DELAY) begin
                     dly   <= dly_load;
                     state <= S_DELAY;
                  end else begin
                     ip_addr  <= DEV_ADDR;
                     sub_addr <= entry_addr;
                     data_in  <= entry_data;
`ifdef SCCB_READBACK_VERIFY_EN
                     rw_q     <= 1'b0;
`endif
                     state    <= S_WR_REQ;
                  end
               end
               S_WR_REQ: begin
                  start <= 1'b1;
                  tmo   <= '0;
                  state <= S_WR_WAIT;
               end
               S_WR_WAIT: begin
                  start <= 1'b0;
                  tmo   <= '0;
                  state <= S_REL;
               end
               S_REL: begin
`ifdef SCCB_READBACK_VERIFY_EN
                  if (entry_addr != ADDR_COM7) begin
                     state <= S_RD_REQ;
                  end else begin
                     index <= index + 5'd1;
                     state <= S_FETCH;
                  end
`else
                  index <= index + 5'd1;
                  state <= S_FETCH;
`endif
               end
               S_DELAY: begin
                  if (dly == 16'd0) begin
                     index <= index + 5'd1;
                     state <= S_FETCH;
                  end else begin
                     dly <= dly - 16'd1;
                  end
               end
`ifdef SCCB_READBACK_VERIFY_EN
               S_RD_REQ: begin
                  rw_q  <= 1'b1;
                  start <= 1'b1;
                  tmo   <= '0;
                  state <= S_RD_WAIT;
               end
               S_RD_WAIT: begin
                  start <= 1'b0;
                  tmo   <= '0;
                  state <= S_RD_REL;
               end
               S_RD_REL: begin
                  if (data_out != entry_data) begin
                     state     <= S_ERR;
                     error     <= 1'b1;
                     err_index <= index;
                     busy      <= 1'b0;
                  end else begin
                     index <= index + 5'd1;
                     state <= S_FETCH;
                  end
               end
`endif
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Randomised self-checking bench for sccb_init_sequencer with a CoreSCCB behavioural model.
// Honours SCCB_READBACK_VERIFY_EN to expect the read-back transactions as well.
module tb_sccb_init_sequencer;

   localparam logic [6:0] DEV        = 7'h21;
   localparam int         DELAY_UNIT = 100;
   localparam int         TIMEOUT    = 4095;
`ifdef SCCB_READBACK_VERIFY_EN
   localparam bit READBACK = 1'b1;
`else
   localparam bit READBACK = 1'b0;
`endif

   typedef struct packed {
      logic       rw;
      logic [6:0] dev;
      logic [7:0] addr;
      logic [7:0] data;
   } txn_t;

   logic       PCLK, PRESETN, step, go, done;
   logic       start, rw, busy, cfg_done, error;
   logic [6:0] ip_addr;
   logic [7:0] sub_addr, data_in, data_out;
   logic [4:0] err_index;

   sccb_init_sequencer #(.DEV_ADDR(DEV), .DELAY_UNIT(DELAY_UNIT), .TIMEOUT(TIMEOUT)) dut (
      .PCLK(PCLK), .PRESETN(PRESETN), .step(step), .go(go),
      .start(start), .rw(rw), .ip_addr(ip_addr), .sub_addr(sub_addr), .data_in(data_in),
      .done(done), .data_out(data_out), .busy(busy), .cfg_done(cfg_done),
      .error(error), .err_index(err_index)
   );

   initial begin
      PCLK = 1'b0;
      forever #5 PCLK = ~PCLK;
   end

   int n_cmp = 0;
   int n_bad = 0;

   // Reference init table as listed for the OV7670 bring-up.
   logic [15:0] init_tbl [0:6] = '{16'h1280, 16'hF00A, 16'h1214, 16'h40D0,
                                   16'h8C00, 16'h1101, 16'hFFFF};

   txn_t exp_q[$];
   txn_t txq[$];
   int   rise_q[$];
   int   fall_q[$];
   int   step_cnt;
   logic [7:0] mem [256];

   // CoreSCCB model controls: 0 normal, 1 never acks, 2 done stuck high after first ack.
   int   mode;
   int   ack_lat;
   int   ack_cnt;
   bit   corrupt_40;
   bit   start_prev;
   bit   go_jitter;

   function automatic logic [32:0] out_vec();
      return {start, rw, ip_addr, sub_addr, data_in, busy, cfg_done, error, err_index};
   endfunction

   // Transactions the table should produce: one write per register entry, plus a
   // read-back of every non-COM7 register when verification is built in.
   task automatic build_expected();
      logic [15:0] e;
      txn_t t;
      exp_q.delete();
      for (int i = 0; i < 32; i++) begin
         e = (i < 7) ? init_tbl[i] : 16'hFFFF;
         if (e[15:8] == 8'hFF) break;
         if (e[15:8] == 8'hF0) continue;
         t = '{1'b0, DEV, e[15:8], e[7:0]};
         exp_q.push_back(t);
         if (READBACK && e[15:8] != 8'h12) begin
            t.rw = 1'b1;
            exp_q.push_back(t);
         end
      end
   endtask

   task automatic model_step();
      txn_t t;
      step_cnt++;
      if (start && !start_prev) begin
         t = '{rw, ip_addr, sub_addr, data_in};
         txq.push_back(t);
         rise_q.push_back(step_cnt);
         ack_cnt = 0;
         if (rw) data_out = mem[sub_addr] ^ ((corrupt_40 && sub_addr == 8'h40) ? 8'h01 : 8'h00);
         else    mem[sub_addr] = data_in;
      end
      if (!start && start_prev) fall_q.push_back(step_cnt);
      if (mode != 1) begin
         if (start && !done) begin
            ack_cnt++;
            if (ack_cnt >= ack_lat) done = 1'b1;
         end else if (!start && done && mode == 0) begin
            done = 1'b0;
         end
      end
      start_prev = start;
   endtask

   task automatic tick(input bit en);
      @(negedge PCLK);
      step = en ? 1'($urandom_range(0, 1)) : 1'b0;
      if (go_jitter) go = 1'($urandom_range(0, 1));
      @(posedge PCLK);
      #1;
      if (PRESETN && step) model_step();
   endtask

   task automatic do_reset();
      @(negedge PCLK);
      PRESETN = 1'b0; step = 1'b0; go = 1'b0; go_jitter = 1'b0;
      done = 1'b0; data_out = 8'h00; start_prev = 1'b0;
      repeat (2) @(negedge PCLK);
      txq.delete(); rise_q.delete(); fall_q.delete();
      step_cnt = 0; mode = 0; ack_lat = 3; ack_cnt = 0; corrupt_40 = 1'b0;
      PRESETN = 1'b1;
   endtask

   task automatic start_seq(input string tag);
      int n = 0;
      go = 1'b1;
      while (!busy && n < 100) begin tick(1'b1); n++; end
      if (!busy) begin
         n_cmp++; n_bad++;
         $display("FAIL %s_go: busy=%b required 1 within 100 cycles", tag, busy);
      end
      go_jitter = 1'b1;
   endtask

   task automatic run_to_end(input int budget, input string tag);
      int n = 0;
      while (!cfg_done && !error && n < budget) begin tick(1'b1); n++; end
      go_jitter = 1'b0;
      go = 1'b0;
      if (n >= budget) begin
         n_cmp++; n_bad++;
         $display("FAIL %s_end: no cfg_done/error within %0d cycles", tag, budget);
      end
   endtask

   task automatic test_reset();
      @(negedge PCLK);
      PRESETN = 1'b0;
      #1;
      n_cmp++;
      if (out_vec() !== 33'd0) begin
         n_bad++; $display("FAIL reset_outputs: got %h required 0", out_vec());
      end
      do_reset();
      repeat (20) tick(1'b1);
      n_cmp++;
      if (out_vec() !== 33'd0) begin
         n_bad++; $display("FAIL idle_without_go: got %h required 0", out_vec());
      end
   endtask

   task automatic test_full_sequence(input int lat, input string tag);
      int gap0, gap1;
      do_reset();
      ack_lat = lat;
      start_seq(tag);
      run_to_end(12000, tag);
      n_cmp++;
      if (txq.size() !== exp_q.size()) begin
         n_bad++; $display("FAIL %s_count: got %0d txns required %0d", tag, txq.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < txq.size(); i++) begin
         n_cmp++;
         if (txq[i] !== exp_q[i]) begin
            n_bad++; $display("FAIL %s_txn%0d: got %h required %h", tag, i, txq[i], exp_q[i]);
         end
      end
      n_cmp++;
      if ({cfg_done, busy, error, start} !== 4'b1000) begin
         n_bad++; $display("FAIL %s_status: cfg_done/busy/error/start=%b required 1000", tag,
                           {cfg_done, busy, error, start});
      end
      // Between two writes the delay entry adds its marker fetch, 10*DELAY_UNIT
      // decrement steps and one final step at zero, compared to a plain gap.
      n_cmp++;
      if (rise_q.size() >= 3 && fall_q.size() >= 2) begin
         gap0 = rise_q[1] - fall_q[0];
         gap1 = rise_q[2] - fall_q[1];
         if (gap0 - gap1 !== 10 * DELAY_UNIT + 2) begin
            n_bad++; $display("FAIL %s_delay: extra steps %0d required %0d", tag, gap0 - gap1,
                              10 * DELAY_UNIT + 2);
         end
      end else begin
         n_bad++; $display("FAIL %s_delay: only %0d starts seen, required at least 3", tag, rise_q.size());
      end
   endtask

   task automatic test_step_hold();
      logic [32:0] snap;
      int n = 0;
      int changes = 0;
      do_reset();
      start_seq("hold");
      while (txq.size() < 2 && !error && n < 8000) begin tick(1'b1); n++; end
      snap = out_vec();
      for (int i = 0; i < 1000; i++) begin
         tick(1'b0);
         if (out_vec() !== snap) changes++;
      end
      n_cmp++;
      if (changes !== 0 || txq.size() < 2) begin
         n_bad++; $display("FAIL hold_frozen: %0d changed cycles, %0d txns, required 0 and >=2",
                           changes, txq.size());
      end
      run_to_end(12000, "hold");
      n_cmp++;
      if ({cfg_done, error} !== 2'b10 || txq.size() !== exp_q.size()) begin
         n_bad++; $display("FAIL hold_resume: cfg_done/error=%b txns=%0d required 10 and %0d",
                           {cfg_done, error}, txq.size(), exp_q.size());
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      do_reset();
      start_seq("midrst");
      while (!(start && !rw && sub_addr == 8'h40) && !error && n < 8000) begin tick(1'b1); n++; end
      n_cmp++;
      if (!(start && !rw && sub_addr == 8'h40)) begin
         n_bad++; $display("FAIL midrst_reach: entry 3 write never seen, sub_addr=%h start=%b", sub_addr, start);
      end
      @(negedge PCLK);
      PRESETN = 1'b0;
      #1;
      n_cmp++;
      if (out_vec() !== 33'd0) begin
         n_bad++; $display("FAIL midrst_outputs: got %h required 0", out_vec());
      end
      do_reset();
      start_seq("midrst2");
      run_to_end(12000, "midrst2");
      n_cmp++;
      if (txq.size() < 1 || txq[0] !== exp_q[0] || txq.size() !== exp_q.size() || cfg_done !== 1'b1) begin
         n_bad++; $display("FAIL midrst_restart: txns=%0d cfg_done=%b required %0d txns from 12/80 and 1",
                           txq.size(), cfg_done, exp_q.size());
      end
   endtask

   task automatic test_no_done();
      int n = 0;
      int steps = 0;
      do_reset();
      mode = 1;
      start_seq("nodone");
      while (!start && n < 200) begin tick(1'b1); n++; end
      n = 0;
      while (!error && n < 20000) begin
         tick(1'b1);
         n++;
         if (step) steps++;
      end
      n_cmp++;
      if (steps !== TIMEOUT + 1) begin
         n_bad++; $display("FAIL nodone_steps: error after %0d steps required %0d", steps, TIMEOUT + 1);
      end
      n_cmp++;
      if ({error, start, busy, cfg_done, err_index} !== {4'b1000, 5'd0}) begin
         n_bad++; $display("FAIL nodone_status: error/start/busy/cfg_done=%b err_index=%0d required 1000 and 0",
                           {error, start, busy, cfg_done}, err_index);
      end
   endtask

   task automatic test_stuck_done();
      do_reset();
      mode = 2;
      start_seq("stuck");
      run_to_end(20000, "stuck");
      n_cmp++;
      if ({error, start, busy, cfg_done, err_index} !== {4'b1000, 5'd0}) begin
         n_bad++; $display("FAIL stuck_status: error/start/busy/cfg_done=%b err_index=%0d required 1000 and 0",
                           {error, start, busy, cfg_done}, err_index);
      end
      n_cmp++;
      if (txq.size() !== 1) begin
         n_bad++; $display("FAIL stuck_txns: got %0d required 1", txq.size());
      end
   endtask

`ifdef SCCB_READBACK_VERIFY_EN
   task automatic test_readback_mismatch();
      int reads = 0;
      do_reset();
      corrupt_40 = 1'b1;
      start_seq("rbbad");
      run_to_end(12000, "rbbad");
      foreach (txq[i]) if (txq[i].rw) reads++;
      n_cmp++;
      if ({error, cfg_done, busy, err_index} !== {3'b100, 5'd3}) begin
         n_bad++; $display("FAIL rbbad_status: error/cfg_done/busy=%b err_index=%0d required 100 and 3",
                           {error, cfg_done, busy}, err_index);
      end
      n_cmp++;
      if (reads !== 1) begin
         n_bad++; $display("FAIL rbbad_reads: got %0d required 1", reads);
      end
   endtask
`endif

   initial begin
      PRESETN = 1'b1; step = 1'b0; go = 1'b0; done = 1'b0; data_out = 8'h00;
      go_jitter = 1'b0; start_prev = 1'b0;
      mode = 0; ack_lat = 3; ack_cnt = 0; corrupt_40 = 1'b0; step_cnt = 0;
      build_expected();
      test_reset();
      test_full_sequence(3, "seq_lat3");
      test_full_sequence(int'($urandom_range(1, 6)), "seq_rand");
      test_step_hold();
      test_reset_mid();
      test_no_done();
      test_stuck_done();
`ifdef SCCB_READBACK_VERIFY_EN
      test_readback_mismatch();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
